// File: rtl/ppu_vram_port_if.sv
// CPU register-bus and PPU-memory-bus bundles for ppu_vram_port.
// The CPU side is strobe/ready/ack; the memory side holds each request until mem_ack.
interface ppu_cpu_if;
  logic       cpu_req;
  logic       cpu_rw;
  logic [2:0] cpu_reg;
  logic [7:0] cpu_din;
  logic [7:0] cpu_dout;
  logic       cpu_ready;
  logic       cpu_ack;
  logic       ctrl_inc32;

  modport master (output cpu_req, cpu_rw, cpu_reg, cpu_din, ctrl_inc32,
                  input  cpu_dout, cpu_ready, cpu_ack);
  modport slave  (input  cpu_req, cpu_rw, cpu_reg, cpu_din, ctrl_inc32,
                  output cpu_dout, cpu_ready, cpu_ack);
endinterface

interface ppu_mem_if;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;

  modport master (output mem_addr, mem_rd, mem_wr, mem_wdata,
                  input  mem_rdata, mem_ack);
  modport slave  (input  mem_addr, mem_rd, mem_wr, mem_wdata,
                  output mem_rdata, mem_ack);
endinterface

// File: rtl/ppu_vram_port.sv
// PPUADDR/PPUDATA initiator: two-write address latch, read buffer, auto-increment; ack 1 cycle after
// register-only accesses, memory wait + 2 otherwise. CPU strobes are dropped while busy; mem requests held until mem_ack.
module ppu_vram_port #(
  parameter logic [15:0] PAL_BASE = 16'h3F00,
  parameter logic [15:0] NT_UNDER = 16'h1000
) (
  input logic     clk,
  input logic     reset_n,
  ppu_cpu_if.slave  cpu,
  ppu_mem_if.master mem
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] WR   = 3'd1;
  localparam logic [2:0] RD   = 3'd2;
  localparam logic [2:0] FILL = 3'd3;
  localparam logic [2:0] ACK  = 3'd4;

  logic [2:0]  state;
  logic [13:0] v;
  logic [13:0] addr;
  logic [5:0]  t_hi;
  logic        w;
  logic [7:0]  rbuf;
  logic [7:0]  dout;
  logic [7:0]  wdata;
  logic        rd;
  logic        wr;

  logic [13:0] inc;
  logic [13:0] v_next;
  logic [13:0] fill_addr;
  logic        is_pal;

  assign inc       = cpu.ctrl_inc32 ? 14'd32 : 14'd1;
  assign v_next    = v + inc;
  assign fill_addr = v - NT_UNDER[13:0];
  assign is_pal    = ({2'b00, v} >= PAL_BASE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      v     <= '0;
      addr  <= '0;
      t_hi  <= '0;
      w     <= 1'b0;
      rbuf  <= '0;
      dout  <= '0;
      wdata <= '0;
      rd    <= 1'b0;
      wr    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu.cpu_req) begin
            state <= ACK;
            if (!cpu.cpu_rw && cpu.cpu_reg == 3'd6) begin
              if (!w) begin
                t_hi <= cpu.cpu_din[5:0];
                w    <= 1'b1;
              end else begin
                v <= {t_hi, cpu.cpu_din};
                w <= 1'b0;
              end
            end else if (cpu.cpu_rw && cpu.cpu_reg == 3'd2) begin
              w <= 1'b0;
            end else if (cpu.cpu_reg == 3'd7) begin
              addr <= v;
              if (cpu.cpu_rw) begin
                rd    <= 1'b1;
                state <= RD;
              end else begin
                wdata <= cpu.cpu_din;
                wr    <= 1'b1;
                state <= WR;
              end
            end
          end
        end
        WR: begin
          if (mem.mem_ack) begin
            wr    <= 1'b0;
            v     <= v_next;
            state <= ACK;
          end
        end
        RD: begin
          if (mem.mem_ack) begin
            if (is_pal) begin
              // Palette data goes straight out; the buffer is refilled from the nametable underneath.
              dout  <= mem.mem_rdata;
              addr  <= fill_addr;
              state <= FILL;
            end else begin
              rd    <= 1'b0;
              dout  <= rbuf;
              rbuf  <= mem.mem_rdata;
              v     <= v_next;
              state <= ACK;
            end
          end
        end
        FILL: begin
          if (mem.mem_ack) begin
            rbuf  <= mem.mem_rdata;
            rd    <= 1'b0;
            v     <= v_next;
            state <= ACK;
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign cpu.cpu_ready = (state == IDLE);
  assign cpu.cpu_ack   = (state == ACK);
  assign cpu.cpu_dout  = dout;
  assign mem.mem_addr  = {2'b00, addr};
  assign mem.mem_rd    = rd;
  assign mem.mem_wr    = wr;
  assign mem.mem_wdata = wdata;

endmodule

// File: tb/tb_ppu_vram_port.sv
// Randomized bench for ppu_vram_port: a register-level model of PPUADDR/PPUDATA predicts
// every memory access and every read result; a responder with random latency plays the memory.
module tb_ppu_vram_port;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ppu_cpu_if cpu_bus ();
  ppu_mem_if mem_bus ();

  ppu_vram_port dut (
    .clk     (clk),
    .reset_n (reset_n),
    .cpu     (cpu_bus.slave),
    .mem     (mem_bus.master)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory contents and access logs ({wr, addr16, data8})
  logic [7:0]  mem [0:16383];
  logic [24:0] act_q[$];
  logic [24:0] exp_q[$];
  bit          stall = 1'b0;
  bit          late_ack = 1'b0;
  int          wait_cnt = 0;

  initial begin
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      mem_bus.mem_ack   = 1'b0;
      mem_bus.mem_rdata = 8'($urandom);
      if (mem_bus.mem_rd || mem_bus.mem_wr)
        chk("rd_wr_exclusive", {31'd0, mem_bus.mem_rd & mem_bus.mem_wr}, 32'd0);
      if (!reset_n) begin
        wait_cnt = 0;
      end else if (stall) begin
        mem_bus.mem_ack = late_ack;
      end else if (mem_bus.mem_rd || mem_bus.mem_wr) begin
        if (wait_cnt == 0) begin
          chk("addr_hi_zero", {30'd0, mem_bus.mem_addr[15:14]}, 32'd0);
          if (mem_bus.mem_wr) begin
            act_q.push_back({1'b1, mem_bus.mem_addr, mem_bus.mem_wdata});
            mem[mem_bus.mem_addr[13:0]] = mem_bus.mem_wdata;
          end else begin
            act_q.push_back({1'b0, mem_bus.mem_addr, 8'h00});
            mem_bus.mem_rdata = mem[mem_bus.mem_addr[13:0]];
          end
          mem_bus.mem_ack = 1'b1;
          wait_cnt = $urandom_range(0, 3);
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  // Reference model: PPU register state at the architectural level
  logic [13:0] m_v;
  logic [5:0]  m_t;
  bit          m_w;
  logic [7:0]  m_rbuf;
  logic [7:0]  m_dout;

  task automatic model_reset();
    m_v = 14'd0; m_t = 6'd0; m_w = 1'b0; m_rbuf = 8'd0; m_dout = 8'd0;
  endtask

  task automatic model_access(input logic [2:0] r, input bit rw, input logic [7:0] d, input bit i32);
    int step;
    int a;
    step = i32 ? 32 : 1;
    if (r == 3'd6 && !rw) begin
      if (!m_w) begin m_t = d[5:0]; m_w = 1'b1; end
      else begin m_v = {m_t, d}; m_w = 1'b0; end
    end else if (r == 3'd2 && rw) begin
      m_w = 1'b0;
    end else if (r == 3'd7 && !rw) begin
      exp_q.push_back({1'b1, 2'b00, m_v, d});
      m_v = 14'((int'(m_v) + step) % 16384);
    end else if (r == 3'd7 && rw) begin
      exp_q.push_back({1'b0, 2'b00, m_v, 8'h00});
      if (int'(m_v) >= 'h3F00) begin
        a = int'(m_v) - 'h1000;
        exp_q.push_back({1'b0, 2'b00, 14'(a), 8'h00});
        m_dout = mem[m_v];
        m_rbuf = mem[14'(a)];
      end else begin
        m_dout = m_rbuf;
        m_rbuf = mem[m_v];
      end
      m_v = 14'((int'(m_v) + step) % 16384);
    end
  endtask

  task automatic compare_accesses();
    int n;
    chk("access_count", act_q.size(), exp_q.size());
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk("access", {7'd0, act_q[i]}, {7'd0, exp_q[i]});
    act_q.delete();
    exp_q.delete();
  endtask

  // One CPU register access; called and returns at a negedge.
  task automatic access(input logic [2:0] r, input bit rw, input logic [7:0] d, input bit i32,
                        input bit spurious);
    int n;
    chk("ready_before_req", {31'd0, cpu_bus.cpu_ready}, 32'd1);
    cpu_bus.cpu_reg = r; cpu_bus.cpu_rw = rw; cpu_bus.cpu_din = d;
    cpu_bus.ctrl_inc32 = i32; cpu_bus.cpu_req = 1'b1;
    @(negedge clk);
    cpu_bus.cpu_req = 1'b0;
    n = 1;
    if (spurious && r == 3'd7 && !cpu_bus.cpu_ack) begin
      // Busy: this strobe must be dropped, not queued.
      cpu_bus.cpu_reg = 3'd6; cpu_bus.cpu_rw = 1'b0; cpu_bus.cpu_din = 8'h2A; cpu_bus.cpu_req = 1'b1;
      @(negedge clk);
      cpu_bus.cpu_req = 1'b0;
      n++;
    end
    while (!cpu_bus.cpu_ack && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("ack_seen", {31'd0, cpu_bus.cpu_ack}, 32'd1);
    if (r != 3'd7) chk("reg_latency", n, 1);
    model_access(r, rw, d, i32);
    if (r == 3'd7 && rw) chk("read_dout", {24'd0, cpu_bus.cpu_dout}, {24'd0, m_dout});
    @(negedge clk);
    chk("ack_one_cycle", {31'd0, cpu_bus.cpu_ack}, 32'd0);
    chk("dout_held", {24'd0, cpu_bus.cpu_dout}, {24'd0, m_dout});
    compare_accesses();
  endtask

  task automatic set_addr(input logic [15:0] a);
    access(3'd6, 1'b0, a[15:8], 1'b0, 1'b0);
    access(3'd6, 1'b0, a[7:0], 1'b0, 1'b0);
  endtask

  initial begin
    logic [2:0] regs [0:6];
    logic [2:0] r;
    logic [7:0] d;
    bit rw;
    regs[0] = 3'd2; regs[1] = 3'd6; regs[2] = 3'd7; regs[3] = 3'd7;
    regs[4] = 3'd6; regs[5] = 3'd0; regs[6] = 3'd5;
    for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom);
    cpu_bus.cpu_req = 1'b0; cpu_bus.cpu_rw = 1'b0; cpu_bus.cpu_reg = 3'd0;
    cpu_bus.cpu_din = 8'd0; cpu_bus.ctrl_inc32 = 1'b0;
    model_reset();

    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, cpu_bus.cpu_ready}, 32'd1);
    chk("rst_ack", {31'd0, cpu_bus.cpu_ack}, 32'd0);
    chk("rst_rd_wr", {30'd0, mem_bus.mem_rd, mem_bus.mem_wr}, 32'd0);
    chk("rst_addr", {16'd0, mem_bus.mem_addr}, 32'd0);
    chk("rst_wdata", {24'd0, mem_bus.mem_wdata}, 32'd0);
    chk("rst_dout", {24'd0, cpu_bus.cpu_dout}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Address latch then data write; the follow-up write shows v advanced to 0x2109
    set_addr(16'h2108);
    access(3'd7, 1'b0, 8'h55, 1'b0, 1'b0);
    access(3'd7, 1'b0, 8'h66, 1'b0, 1'b0);

    // Buffered reads
    mem[14'h2000] = 8'hAA; mem[14'h2001] = 8'hBB;
    set_addr(16'h2000);
    access(3'd7, 1'b1, 8'h00, 1'b0, 1'b0);
    chk("buf_read0", {24'd0, cpu_bus.cpu_dout}, 32'h00);
    access(3'd7, 1'b1, 8'h00, 1'b0, 1'b0);
    chk("buf_read1", {24'd0, cpu_bus.cpu_dout}, 32'hAA);

    // Palette read bypasses the buffer and refills it from 0x2F05
    mem[14'h3F05] = 8'h1C; mem[14'h2F05] = 8'h77;
    set_addr(16'h3F05);
    access(3'd7, 1'b1, 8'h00, 1'b0, 1'b1);
    chk("pal_read", {24'd0, cpu_bus.cpu_dout}, 32'h1C);
    set_addr(16'h2000);
    access(3'd7, 1'b1, 8'h00, 1'b0, 1'b0);
    chk("pal_refill", {24'd0, cpu_bus.cpu_dout}, 32'h77);

    // Increment wrap at the top of the 14-bit space
    set_addr(16'h3FF0);
    access(3'd7, 1'b0, 8'h01, 1'b1, 1'b0);
    access(3'd7, 1'b0, 8'h02, 1'b0, 1'b0);
    set_addr(16'h3FFF);
    access(3'd7, 1'b0, 8'h03, 1'b0, 1'b0);
    access(3'd7, 1'b0, 8'h04, 1'b0, 1'b0);

    // $2002 read clears the write toggle
    access(3'd6, 1'b0, 8'h3F, 1'b0, 1'b0);
    access(3'd2, 1'b1, 8'h00, 1'b0, 1'b0);
    set_addr(16'h1234);
    access(3'd7, 1'b0, 8'h5A, 1'b0, 1'b0);

    // Reset while WR waits on memory, with w=1 beforehand
    access(3'd6, 1'b0, 8'h15, 1'b0, 1'b0);
    stall = 1'b1;
    cpu_bus.cpu_reg = 3'd7; cpu_bus.cpu_rw = 1'b0; cpu_bus.cpu_din = 8'h99; cpu_bus.cpu_req = 1'b1;
    @(negedge clk);
    cpu_bus.cpu_req = 1'b0;
    @(negedge clk);
    chk("wr_pending", {31'd0, mem_bus.mem_wr}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("arst_wr", {31'd0, mem_bus.mem_wr}, 32'd0);
    chk("arst_ready", {31'd0, cpu_bus.cpu_ready}, 32'd1);
    chk("arst_addr", {16'd0, mem_bus.mem_addr}, 32'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    late_ack = 1'b1;
    @(negedge clk);
    late_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_noack", {31'd0, cpu_bus.cpu_ack}, 32'd0);
    chk("late_ack_idle", {31'd0, cpu_bus.cpu_ready}, 32'd1);
    chk("late_ack_rdwr", {30'd0, mem_bus.mem_rd, mem_bus.mem_wr}, 32'd0);
    stall = 1'b0;
    act_q.delete();
    access(3'd7, 1'b1, 8'h00, 1'b0, 1'b0);
    set_addr(16'h1234);
    access(3'd7, 1'b0, 8'hC3, 1'b0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      r  = regs[$urandom_range(0, 6)];
      rw = 1'($urandom);
      d  = 8'($urandom);
      if (r == 3'd6 && !rw && !m_w && $urandom_range(0, 3) == 0) d = 8'h3F;
      access(r, rw, d, 1'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
